mem_access_unit: RTL and testbench

- M-stage consumer of the EX/MEM pipeline register outputs in the 5-stage MIPS core.
- Issues word accesses to the data-memory bus using a req/ack handshake, and stalls the pipeline while a request is outstanding.
- Registers the M-stage results into the MEM/WB boundary for writeback.

---
 rtl/mem_access_unit_pkg.sv | 20 ++
 rtl/mem_access_unit_mem_wb.sv | 35 +++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the M-stage memory access unit.
// State encodings and the MEM/WB payload struct live here.
package mem_access_unit_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  wreg;
    logic        regwrite;
    logic        memtoreg;
  } wb_t;

endpackage

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register with a bubble input that kills the write-enables
// while the M stage is stalled (or an access is aborted).
module mem_wb
  import mem_access_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_bubble,
  input  wb_t  i_wb,
  output wb_t  o_wb
);

  wb_t r_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb <= '0;
    end else begin
      // Load data is already zeroed upstream unless a load completes.
      r_wb.rdata <= i_wb.rdata;
      if (i_bubble) begin
        r_wb.regwrite <= 1'b0;
        r_wb.memtoreg <= 1'b0;
      end else begin
        r_wb.alu      <= i_wb.alu;
        r_wb.wreg     <= i_wb.wreg;
        r_wb.regwrite <= i_wb.regwrite;
        r_wb.memtoreg <= i_wb.memtoreg;
      end
    end
  end

  assign o_wb = r_wb;

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory access: req/ack bus FSM, pipeline stall, MEM/WB register.
// Optional MEM_TIMEOUT_EN adds a WAIT-state timeout with a sticky busErr flag.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       aluOutM,
  input  logic [31:0]       writeDataM,
  input  logic [4:0]        writeRegM,
  input  logic              regWriteM,
  input  logic              memToRegM,
  input  logic              memWriteM,
  output logic              dataReq,
  output logic              dataWe,
  output logic [ADDR_W-1:0] dataAddr,
  output logic [31:0]       dataWdata,
  input  logic [31:0]       dataRdata,
  input  logic              dataAck,
  output logic              stallM,
  output logic [31:0]       aluOutW,
  output logic [31:0]       readDataW,
  output logic [4:0]        writeRegW,
  output logic              regWriteW,
  output logic              memToRegW
`ifdef MEM_TIMEOUT_EN
  , output logic            busErr
`endif
);

  mem_state_t r_state, w_next;
  logic       w_mem_op, w_req, w_timeout, w_ld_done, w_bubble;
  wb_t        w_wb_in, w_wb_out;

  assign w_mem_op = memToRegM | memWriteM;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= MEM_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        w_req = w_mem_op;
        if (w_mem_op && !dataAck) w_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        // Upstream is frozen, so address/data/we on the bus stay stable here.
        w_req = 1'b1;
        if (dataAck) w_next = MEM_IDLE;
`ifdef MEM_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout = 1'b1;
          w_next    = MEM_IDLE;
        end
`endif
      end
      default: w_next = MEM_IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == MEM_IDLE) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 1'b1;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end
  assign busErr = r_bus_err;
`endif

  assign dataReq   = w_req;
  assign dataWe    = memWriteM & w_req;
  assign dataAddr  = aluOutM[ADDR_W-1:0];
  assign dataWdata = writeDataM;
  assign stallM    = w_mem_op & ~dataAck & ~w_timeout;

  // A store wins over a load when both flags are set.
  assign w_ld_done = w_req & dataAck & memToRegM & ~memWriteM;
  assign w_bubble  = stallM | w_timeout;

  always_comb begin
    w_wb_in          = '0;
    w_wb_in.alu      = aluOutM;
    w_wb_in.rdata    = w_ld_done ? dataRdata : ZERO_WORD;
    w_wb_in.wreg     = writeRegM;
    w_wb_in.regwrite = regWriteM & ~memWriteM;
    w_wb_in.memtoreg = memToRegM & ~memWriteM;
  end

  mem_wb u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (w_bubble),
    .i_wb     (w_wb_in),
    .o_wb     (w_wb_out)
  );

  assign aluOutW   = w_wb_out.alu;
  assign readDataW = w_wb_out.rdata;
  assign writeRegW = w_wb_out.wreg;
  assign regWriteW = w_wb_out.regwrite;
  assign memToRegW = w_wb_out.memtoreg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; define MEM_TIMEOUT_EN to also cover the
// timeout path (built with TIMEOUT_CYCLES=4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aluOutM, writeDataM, dataRdata;
  logic [4:0]  writeRegM;
  logic        regWriteM, memToRegM, memWriteM, dataAck;
  logic        dataReq, dataWe, stallM;
  logic [31:0] dataAddr, dataWdata, aluOutW, readDataW;
  logic [4:0]  writeRegW;
  logic        regWriteW, memToRegW;
`ifdef MEM_TIMEOUT_EN
  logic        busErr;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W(32)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .aluOutM(aluOutM), .writeDataM(writeDataM), .writeRegM(writeRegM),
    .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
    .dataReq(dataReq), .dataWe(dataWe), .dataAddr(dataAddr), .dataWdata(dataWdata),
    .dataRdata(dataRdata), .dataAck(dataAck), .stallM(stallM),
    .aluOutW(aluOutW), .readDataW(readDataW), .writeRegW(writeRegW),
    .regWriteW(regWriteW), .memToRegW(memToRegW)
`ifdef MEM_TIMEOUT_EN
    , .busErr(busErr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and W outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluOutM = 0; writeDataM = 0; writeRegM = 0; regWriteM = 0;
    memToRegM = 0; memWriteM = 0; dataAck = 0; dataRdata = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    chk("rst_aluOutW", aluOutW, 0);
    chk("rst_readDataW", readDataW, 0);
    chk("rst_writeRegW", {27'd0, writeRegW}, 0);
    chk("rst_regWriteW", {31'd0, regWriteW}, 0);
    chk("rst_memToRegW", {31'd0, memToRegW}, 0);
    rst = 1'b0;

    // Zero-wait load
    memToRegM = 1; aluOutM = 32'h100; dataAck = 1; dataRdata = 32'hDEADBEEF;
    regWriteM = 1; writeRegM = 5'd8;
    #1;
    chk("zw_req", {31'd0, dataReq}, 1);
    chk("zw_we", {31'd0, dataWe}, 0);
    chk("zw_addr", dataAddr, 32'h100);
    chk("zw_stall", {31'd0, stallM}, 0);
    tick();
    chk("zw_rdataW", readDataW, 32'hDEADBEEF);
    chk("zw_regWriteW", {31'd0, regWriteW}, 1);
    chk("zw_writeRegW", {27'd0, writeRegW}, 8);
    chk("zw_memToRegW", {31'd0, memToRegW}, 1);

    // Store with 3 wait cycles; regWriteM set to confirm a store never writes back
    idle_inputs();
    memWriteM = 1; aluOutM = 32'h200; writeDataM = 32'h12345678; regWriteM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_req", {31'd0, dataReq}, 1);
      chk("st_we", {31'd0, dataWe}, 1);
      chk("st_stall", {31'd0, stallM}, 1);
      tick();
      chk("st_bubble_regWriteW", {31'd0, regWriteW}, 0);
      chk("st_bubble_memToRegW", {31'd0, memToRegW}, 0);
    end
    dataAck = 1;
    #1;
    chk("st_ack_req", {31'd0, dataReq}, 1);
    chk("st_ack_we", {31'd0, dataWe}, 1);
    chk("st_ack_stall", {31'd0, stallM}, 0);
    chk("st_ack_wdata", dataWdata, 32'h12345678);
    chk("st_ack_addr", dataAddr, 32'h200);
    tick();
    chk("st_done_regWriteW", {31'd0, regWriteW}, 0);
    chk("st_done_readDataW", readDataW, 0);
    chk("st_done_aluOutW", aluOutW, 32'h200);

    // ALU pass-through with a stray ack that must be ignored
    idle_inputs();
    aluOutM = 32'h55; regWriteM = 1; writeRegM = 5'd3; dataAck = 1; dataRdata = 32'hCAFE;
    #1;
    chk("alu_req", {31'd0, dataReq}, 0);
    chk("alu_we", {31'd0, dataWe}, 0);
    chk("alu_stall", {31'd0, stallM}, 0);
    tick();
    chk("alu_aluOutW", aluOutW, 32'h55);
    chk("alu_regWriteW", {31'd0, regWriteW}, 1);
    chk("alu_writeRegW", {27'd0, writeRegW}, 3);
    chk("alu_readDataW", readDataW, 0);
    chk("alu_memToRegW", {31'd0, memToRegW}, 0);

    // Load and store flags together: treated as a store
    idle_inputs();
    memToRegM = 1; memWriteM = 1; regWriteM = 1; dataAck = 1; dataRdata = 32'hBAD0;
    #1;
    chk("both_we", {31'd0, dataWe}, 1);
    tick();
    chk("both_regWriteW", {31'd0, regWriteW}, 0);
    chk("both_memToRegW", {31'd0, memToRegW}, 0);
    chk("both_readDataW", readDataW, 0);

    // Reset while a load is waiting
    idle_inputs();
    memToRegM = 1; regWriteM = 1; writeRegM = 5'd9; aluOutM = 32'h300;
    tick(); tick();
    #1;
    chk("rw_stall", {31'd0, stallM}, 1);
    rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    #1;
    chk("rw_req_idle", {31'd0, dataReq}, 0);
    chk("rw_aluOutW", aluOutW, 0);
    chk("rw_regWriteW", {31'd0, regWriteW}, 0);
    chk("rw_writeRegW", {27'd0, writeRegW}, 0);
    dataAck = 1; dataRdata = 32'h7777;
    #1;
    chk("rw_stray_req", {31'd0, dataReq}, 0);
    chk("rw_stray_stall", {31'd0, stallM}, 0);
    tick();
    chk("rw_stray_readDataW", readDataW, 0);
    chk("rw_stray_memToRegW", {31'd0, memToRegW}, 0);

    // Back-to-back load then store
    idle_inputs();
    memToRegM = 1; regWriteM = 1; writeRegM = 5'd4; aluOutM = 32'h400;
    dataAck = 1; dataRdata = 32'h11112222;
    #1;
    chk("bb_ld_req", {31'd0, dataReq}, 1);
    chk("bb_ld_we", {31'd0, dataWe}, 0);
    tick();
    memToRegM = 0; regWriteM = 0; memWriteM = 1; aluOutM = 32'h404; writeDataM = 32'hABCD;
    #1;
    chk("bb_st_req", {31'd0, dataReq}, 1);
    chk("bb_st_we", {31'd0, dataWe}, 1);
    chk("bb_st_stall", {31'd0, stallM}, 0);
    chk("bb_ld_readDataW", readDataW, 32'h11112222);
    chk("bb_ld_regWriteW", {31'd0, regWriteW}, 1);
    chk("bb_ld_writeRegW", {27'd0, writeRegW}, 4);
    tick();
    chk("bb_st_regWriteW", {31'd0, regWriteW}, 0);
    chk("bb_st_readDataW", readDataW, 0);

`ifdef MEM_TIMEOUT_EN
    // Load that is never acknowledged: aborted after 4 stalled cycles
    idle_inputs();
    chk("to_busErr_init", {31'd0, busErr}, 0);
    memToRegM = 1; regWriteM = 1; writeRegM = 5'd6; aluOutM = 32'h500;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", {31'd0, stallM}, 1);
      tick();
    end
    #1;
    chk("to_abort_stall", {31'd0, stallM}, 0);
    tick();
    chk("to_busErr", {31'd0, busErr}, 1);
    chk("to_regWriteW", {31'd0, regWriteW}, 0);
    chk("to_readDataW", readDataW, 0);
    idle_inputs();
    tick(); tick();
    chk("to_busErr_sticky", {31'd0, busErr}, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("to_busErr_rst", {31'd0, busErr}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
